// File: rtl/fp_comp_arb_if.sv
// ------------------------------------------------------------------------
// fp_comp_arb_if: requester-side request/response bus of the shared FP comparator.
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

interface fp_comp_arb_if #(
  parameter int N = 4,
  parameter int W = 32
);
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [3:0]     rsp_flags;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_flags
  );
endinterface

`default_nettype wire

// File: rtl/fp_comp_arb.sv
// ------------------------------------------------------------------------
// fp_comp_arb: shares one registered FP comparator among N requesters, one op in flight.
// Define FP_COMP_ARB_FIXED_PRIO_EN for fixed lowest-index priority.  Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module fp_comp_arb #(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int CMP_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  fp_comp_arb_if.slave  bus,
  output logic          cmp_act_o,
  output logic [W-1:0]  cmp_in1_o,
  output logic [W-1:0]  cmp_in2_o,
  input  logic          cmp_eq_i,
  input  logic          cmp_great_i,
  input  logic          cmp_less_i,
  input  logic          cmp_inv_i,
  output logic          busy_o
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(CMP_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [GW-1:0]  ptr_q, ptr_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   in1_q, in1_d;
  logic [W-1:0]   in2_q, in2_d;
  logic [3:0]     flags_q, flags_d;

  logic           found;
  logic [GW-1:0]  win;

  // With the pointer held at 0 this search degenerates to lowest-index-first.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    cnt_d         = cnt_q;
    in1_d         = in1_q;
    in2_d         = in2_q;
    flags_d       = flags_q;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    cmp_act_o     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          bus.req_ready[win] = 1'b1;
          grant_d = win;
          in1_d   = bus.req_a[int'(win)*W +: W];
          in2_d   = bus.req_b[int'(win)*W +: W];
          cnt_d   = CW'(CMP_LAT);
`ifdef FP_COMP_ARB_FIXED_PRIO_EN
          ptr_d   = '0;
`else
          ptr_d   = (win == GW'(N-1)) ? '0 : win + GW'(1);
`endif
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cmp_act_o = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          flags_d = {cmp_inv_i, cmp_less_i, cmp_eq_i, cmp_great_i};
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        bus.rsp_valid[grant_q] = 1'b1;
        if (bus.rsp_ready[grant_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      flags_q <= flags_d;
    end
  end

  assign bus.rsp_flags = flags_q;
  assign cmp_in1_o     = in1_q;
  assign cmp_in2_o     = in2_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fp_comp_arb.sv
// ------------------------------------------------------------------------
// tb_fp_comp_arb: directed scoreboard bench for fp_comp_arb (N=4, W=32, CMP_LAT=1).
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_fp_comp_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmp_act, busy;
  logic [31:0] cmp_in1, cmp_in2;
  logic [3:0]  cmp_res = 4'b0000;
  logic        force_inv = 1'b0;

  fp_comp_arb_if #(.N(4), .W(32)) bus ();

  fp_comp_arb #(.N(4), .W(32), .CMP_LAT(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .cmp_act_o   (cmp_act),
    .cmp_in1_o   (cmp_in1),
    .cmp_in2_o   (cmp_in2),
    .cmp_eq_i    (cmp_res[1]),
    .cmp_great_i (cmp_res[0]),
    .cmp_less_i  (cmp_res[2]),
    .cmp_inv_i   (cmp_res[3])
    ,.busy_o     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Comparator stand-in: one-cycle registered IEEE single compare, {inv,less,eq,great}.
  function automatic logic [3:0] fp_cmp(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ka, kb;
    if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0))
      return 4'b1000;
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 4'b0010;
    ka = a[31] ? ~a : (a | 32'h8000_0000);
    kb = b[31] ? ~b : (b | 32'h8000_0000);
    if (ka == kb) return 4'b0010;
    if (ka < kb)  return 4'b0100;
    return 4'b0001;
  endfunction

  always @(posedge clk) cmp_res <= force_inv ? 4'b1000 : fp_cmp(cmp_in1, cmp_in2);

  int n_pass = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    int         idx;
    logic [3:0] flags;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // Monitor: every consumed response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst && ((bus.rsp_valid & bus.rsp_ready) != 4'b0000)) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_grant", 32'(bus.rsp_valid), 32'(4'b0001 << mon_e.idx));
        check("rsp_flags", 32'(bus.rsp_flags), 32'(mon_e.flags));
      end
    end
  end

  task automatic push_exp(input int idx, input logic [3:0] f);
    exp_t e;
    e.idx   = idx;
    e.flags = f;
    sb_q.push_back(e);
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[i*32 +: 32] = a;
    bus.req_b[i*32 +: 32] = b;
  endtask

  task automatic wait_grant(input string name, output logic [3:0] rdy);
    int c = 0;
    rdy = 4'b0000;
    while (c < 50) begin
      @(negedge clk);
      if (bus.req_ready != 4'b0000) break;
      c++;
    end
    rdy = bus.req_ready;
    if (rdy == 4'b0000) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_idle();
    int c = 0;
    while (c < 50) begin
      @(negedge clk);
      if (!busy) break;
      c++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic single_op(input string name, input int i, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] f);
    logic [3:0] rdy;
    push_exp(i, f);
    @(posedge clk); #1;
    set_ops(i, a, b);
    bus.req_valid[i] = 1'b1;
    wait_grant(name, rdy);
    check(name, 32'(rdy), 32'(4'b0001 << i));
    @(posedge clk); #1;
    bus.req_valid[i] = 1'b0;
    wait_idle();
  endtask

  int prev_cyc = -1;

  task automatic grant_step(input string name, input int exp_idx, input bit last);
    logic [3:0] rdy;
    wait_grant(name, rdy);
    check(name, 32'(rdy), 32'(4'b0001 << exp_idx));
    if (prev_cyc >= 0) check({name, "_spacing"}, 32'(cyc - prev_cyc), 32'd4);
    prev_cyc = cyc;
    @(posedge clk); #1;
    if (last) bus.req_valid = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rdy;
    int c;
    bus.req_valid = 4'b0000;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 4'b1111;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_flags", 32'(bus.rsp_flags), 32'd0);
    check("rst_cmp_act",   32'(cmp_act),       32'd0);
    check("rst_cmp_in1",   cmp_in1,            32'd0);
    check("rst_cmp_in2",   cmp_in2,            32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Single request with exact latency
    push_exp(1, 4'b0100);
    @(posedge clk); #1;
    set_ops(1, 32'h3F80_0000, 32'h4000_0000);
    bus.req_valid = 4'b0010;
    @(negedge clk);
    check("single_req_ready", 32'(bus.req_ready), 32'h2);
    @(posedge clk); #1 bus.req_valid = 4'b0000;
    @(negedge clk);
    check("single_cmp_in1", cmp_in1, 32'h3F80_0000);
    check("single_cmp_in2", cmp_in2, 32'h4000_0000);
    check("single_cmp_act", 32'(cmp_act), 32'd1);
    @(negedge clk);
    check("single_rsp_early", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("single_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    wait_idle();

    // Flag patterns
    single_op("flag_eq",  0, 32'h4049_0FDB, 32'h4049_0FDB, 4'b0010);
    single_op("flag_neg", 2, 32'hC000_0000, 32'h3F80_0000, 4'b0100);
    force_inv = 1'b1;
    single_op("flag_inv", 3, 32'h3F80_0000, 32'h4000_0000, 4'b1000);
    force_inv = 1'b0;

    // All four requesting continuously
    set_ops(0, 32'h3F80_0000, 32'h4000_0000);
    set_ops(1, 32'h4000_0000, 32'h3F80_0000);
    set_ops(2, 32'hC000_0000, 32'hC000_0000);
    set_ops(3, 32'h7FC0_0000, 32'h0000_0000);
`ifdef FP_COMP_ARB_FIXED_PRIO_EN
    for (int j = 0; j < 5; j++) push_exp(0, 4'b0100);
`else
    push_exp(0, 4'b0100);
    push_exp(1, 4'b0001);
    push_exp(2, 4'b0010);
    push_exp(3, 4'b1000);
    push_exp(0, 4'b0100);
`endif
    @(posedge clk); #1 bus.req_valid = 4'b1111;
    prev_cyc = -1;
`ifdef FP_COMP_ARB_FIXED_PRIO_EN
    for (int j = 0; j < 5; j++) grant_step("rr_grant", 0, j == 4);
`else
    grant_step("rr_grant0", 0, 1'b0);
    grant_step("rr_grant1", 1, 1'b0);
    grant_step("rr_grant2", 2, 1'b0);
    grant_step("rr_grant3", 3, 1'b0);
    grant_step("rr_grant4", 0, 1'b1);
`endif
    wait_idle();

    // Response backpressure; non-granted rsp_ready bits must be ignored
    push_exp(0, 4'b0100);
    push_exp(2, 4'b0010);
    @(posedge clk); #1;
    set_ops(0, 32'h3F80_0000, 32'h4000_0000);
    set_ops(2, 32'h4049_0FDB, 32'h4049_0FDB);
    bus.rsp_ready = 4'b1110;
    bus.req_valid = 4'b0001;
    wait_grant("bp_grant", rdy);
    check("bp_grant", 32'(rdy), 32'h1);
    @(posedge clk); #1 bus.req_valid = 4'b0100;
    c = 0;
    while (c < 50 && bus.rsp_valid == 4'b0000) begin
      @(negedge clk);
      c++;
    end
    if (bus.rsp_valid == 4'b0000) check("bp_rsp_timeout", 32'd1, 32'd0);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      check("bp_rsp_flags", 32'(bus.rsp_flags), 32'h4);
      check("bp_req_ready", 32'(bus.req_ready), 32'h0);
    end
    @(posedge clk); #1 bus.rsp_ready = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    check("bp_accept", 32'(bus.req_ready), 32'h4);
    @(posedge clk); #1 bus.req_valid = 4'b0000;
    wait_idle();

    // Reset in the middle of an operation
    @(posedge clk); #1;
    set_ops(2, 32'h3F80_0000, 32'h3F80_0000);
    bus.req_valid = 4'b0100;
    wait_grant("abort_grant", rdy);
    check("abort_grant", 32'(rdy), 32'h4);
    @(posedge clk); #1 bus.req_valid = 4'b0000;
    @(negedge clk);
    check("abort_in_wait", 32'(cmp_act), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy",      32'(busy),          32'd0);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_cmp_act",   32'(cmp_act),       32'd0);
    check("abort_cmp_in1",   cmp_in1,            32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Requesters 1 and 3 held; first grant also shows the pointer restarted at 0
    set_ops(1, 32'h4000_0000, 32'h3F80_0000);
    set_ops(3, 32'hC000_0000, 32'h3F80_0000);
`ifdef FP_COMP_ARB_FIXED_PRIO_EN
    push_exp(1, 4'b0001);
    push_exp(1, 4'b0001);
    push_exp(1, 4'b0001);
`else
    push_exp(1, 4'b0001);
    push_exp(3, 4'b0100);
    push_exp(1, 4'b0001);
`endif
    @(posedge clk); #1 bus.req_valid = 4'b1010;
    prev_cyc = -1;
`ifdef FP_COMP_ARB_FIXED_PRIO_EN
    grant_step("pair_grant0", 1, 1'b0);
    grant_step("pair_grant1", 1, 1'b0);
    grant_step("pair_grant2", 1, 1'b1);
`else
    grant_step("pair_grant0", 1, 1'b0);
    grant_step("pair_grant1", 3, 1'b0);
    grant_step("pair_grant2", 1, 1'b1);
`endif
    wait_idle();

    c = 0;
    while (c < 50 && sb_q.size() != 0) begin
      @(negedge clk);
      c++;
    end
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
